// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type and default widths for the instruction cache
package icache_pkg;
    typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} icache_state_t;
    localparam int DEF_LINES = 16;
    localparam int WORD_W = 32;
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage with async read, sync write and clear-all
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clr
);
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [WORD_W-1:0] data [LINES];
    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];
    // valid bits: clear-all wins over a same-cycle fill so an invalidated refill stays invalid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid <= '0;
        else if (clr) valid <= '0;
        else if (we) valid[wr_idx] <= 1'b1;
    end
    // tag/data payload needs no reset; it is qualified by valid
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       PC,
    output logic [WORD_W-1:0] Instr,
    output logic              Stall,
    input  logic              Inval,
    output logic              MemReq,
    output logic [31:0]       MemAdr,
    input  logic              MemAck,
`ifdef ICACHE_STATS_EN
    input  logic [WORD_W-1:0] MemRData,
    output logic [31:0]       HitCount,
    output logic [31:0]       MissCount
`else
    input  logic [WORD_W-1:0] MemRData
`endif
);
    localparam int TAG_W = 30 - IDX_W;
    icache_state_t     state;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit;
    logic              miss;
    logic              fill;
    logic              unused_pc;
    assign unused_pc = ^PC[1:0];
    assign hit    = rd_valid && (rd_tag == PC[31:IDX_W+2]);
    assign miss   = (state == IDLE) && !hit;
    assign fill   = (state == REFILL) && MemAck;
    assign MemReq = (state == REFILL);
    assign Stall  = (state == REFILL) || !hit;
    assign Instr  = Stall ? '0 : rd_data;
    icache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_idx  (PC[IDX_W+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (fill && !Inval),
        .wr_idx  (MemAdr[IDX_W+1:2]),
        .wr_tag  (MemAdr[31:IDX_W+2]),
        .wr_data (MemRData),
        .clr     (Inval)
    );
    // FSM and refill address: latch the missing word address on entry to REFILL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            MemAdr <= '0;
        end else if (miss) begin
            state  <= REFILL;
            MemAdr <= {PC[31:2], 2'b00};
        end else if (fill) begin
            state  <= IDLE;
        end
    end
`ifdef ICACHE_STATS_EN
    // statistics: hits counted per IDLE hit cycle, misses per IDLE->REFILL transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            HitCount  <= HitCount + 32'((state == IDLE) && hit);
            MissCount <= MissCount + 32'(miss);
        end
    end
`endif
endmodule
